// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the scrolling pipe generator.
// Holds the reset/clear layout, the gap table and the LFSR configuration.
package pipe_pkg;

    typedef logic signed [15:0] coord_t;

    localparam coord_t     PIPE_Y_INIT [3] = '{16'sd480, 16'sd680, 16'sd880};
    localparam coord_t     PIPE_X_INIT     = 16'sd420;
    localparam coord_t     GAP_BASE        = 16'sd200;
    localparam coord_t     GAP_TABLE   [4] = '{16'sd300, 16'sd500, 16'sd400, 16'sd600};
    localparam logic [9:0] SCORE_MAX       = 10'd999;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Nine random bits on top of the base keep every gap inside 200..711.
    function automatic coord_t gapFromBits(input logic [8:0] bits);
        return GAP_BASE + $signed({7'd0, bits});
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), reloaded with its seed on reset.
module pipe_lfsr
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    output logic [15:0] state_o
);

    logic [15:0] state_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/pipe_gen.sv
// Scrolls three pipes once per frame, respawns them with a new gap and scores bird passes.
// Define PIPE_RANDOM_EN to draw gaps from pipe_lfsr instead of the fixed gap table.
module pipe_gen
    import pipe_pkg::*;
#(
    parameter int SPEED   = 5,
    parameter int SPACING = 200,
    parameter int Y_MIN   = -100,
    parameter int BIRD_Y  = 100
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               new_frame,
    input  logic               run,
    input  logic               clear,
    output logic signed [15:0] pipe1_pos_x,
    output logic signed [15:0] pipe2_pos_x,
    output logic signed [15:0] pipe3_pos_x,
    output logic signed [15:0] pipe1_pos_y,
    output logic signed [15:0] pipe2_pos_y,
    output logic signed [15:0] pipe3_pos_y,
    output logic [9:0]         score,
    output logic               score_pulse
);

    localparam coord_t SPEED_W   = coord_t'(SPEED);
    localparam coord_t Y_MIN_W   = coord_t'(Y_MIN);
    localparam coord_t BIRD_Y_W  = coord_t'(BIRD_Y);
    localparam coord_t RESPAWN_W = coord_t'(3 * SPACING);

    coord_t     pipeX_q [3];
    coord_t     pipeY_q [3];
    coord_t     pipeX_d [3];
    coord_t     pipeY_d [3];
    logic [9:0] score_q;
    logic       scorePulse_q;
    logic       passAny;
    logic [1:0] respawnCnt;

`ifdef PIPE_RANDOM_EN
    logic [15:0] lfsrState;

    pipe_lfsr u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .state_o (lfsrState)
    );

    // Several respawns in one frame each take a different bit window of the LFSR.
    function automatic coord_t lfsrGap(input logic [15:0] s, input logic [1:0] k);
        case (k)
            2'd0:    return gapFromBits(s[8:0]);
            2'd1:    return gapFromBits(s[15:7]);
            default: return gapFromBits({s[3:0], s[15:11]});
        endcase
    endfunction
`else
    logic [1:0] gapIdx_q;
    logic [1:0] gapIdx_d;
    logic [1:0] tableIdx;
`endif

    always_comb begin
        coord_t nextY;
        nextY      = '0;
        passAny    = 1'b0;
        respawnCnt = 2'd0;
        pipeX_d    = pipeX_q;
        pipeY_d    = pipeY_q;
`ifndef PIPE_RANDOM_EN
        tableIdx   = gapIdx_q;
`endif
        // Pipes are visited in index order so the lowest-numbered respawn gets the first gap.
        for (int i = 0; i < 3; i++) begin
            nextY = pipeY_q[i] - SPEED_W;
            if (pipeY_q[i] > BIRD_Y_W && nextY <= BIRD_Y_W) begin
                passAny = 1'b1;
            end
            if (nextY < Y_MIN_W) begin
                pipeY_d[i] = nextY + RESPAWN_W;
`ifdef PIPE_RANDOM_EN
                pipeX_d[i] = lfsrGap(lfsrState, respawnCnt);
`else
                tableIdx   = gapIdx_q + respawnCnt;
                pipeX_d[i] = GAP_TABLE[tableIdx];
`endif
                respawnCnt = respawnCnt + 2'd1;
            end else begin
                pipeY_d[i] = nextY;
            end
        end
`ifndef PIPE_RANDOM_EN
        gapIdx_d = gapIdx_q + respawnCnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn || (new_frame && clear)) begin
            for (int i = 0; i < 3; i++) begin
                pipeX_q[i] <= PIPE_X_INIT;
                pipeY_q[i] <= PIPE_Y_INIT[i];
            end
            score_q      <= '0;
            scorePulse_q <= 1'b0;
`ifndef PIPE_RANDOM_EN
            gapIdx_q     <= 2'd0;
`endif
        end else if (new_frame && run) begin
            pipeX_q      <= pipeX_d;
            pipeY_q      <= pipeY_d;
            scorePulse_q <= passAny;
            if (passAny && score_q < SCORE_MAX) begin
                score_q <= score_q + 10'd1;
            end
`ifndef PIPE_RANDOM_EN
            gapIdx_q     <= gapIdx_d;
`endif
        end else begin
            scorePulse_q <= 1'b0;
        end
    end

    assign pipe1_pos_x = pipeX_q[0];
    assign pipe2_pos_x = pipeX_q[1];
    assign pipe3_pos_x = pipeX_q[2];
    assign pipe1_pos_y = pipeY_q[0];
    assign pipe2_pos_y = pipeY_q[1];
    assign pipe3_pos_y = pipeY_q[2];
    assign score       = score_q;
    assign score_pulse = scorePulse_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Directed bench for pipe_gen: reset layout, scrolling, respawn, clear priority, hold and score saturation.
// Expected gap values follow the fixed table unless PIPE_RANDOM_EN is defined.
module tb_pipe_gen;

    logic               clk = 1'b0;
    logic               rstn;
    logic               new_frame;
    logic               run;
    logic               clear;
    logic signed [15:0] pipe1_pos_x, pipe2_pos_x, pipe3_pos_x;
    logic signed [15:0] pipe1_pos_y, pipe2_pos_y, pipe3_pos_y;
    logic [9:0]         score;
    logic               score_pulse;

    int   checks = 0;
    int   errors = 0;
    int   pulseCount;
    logic lastPulse;

    always #5 clk = ~clk;

    pipe_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .new_frame   (new_frame),
        .run         (run),
        .clear       (clear),
        .pipe1_pos_x (pipe1_pos_x),
        .pipe2_pos_x (pipe2_pos_x),
        .pipe3_pos_x (pipe3_pos_x),
        .pipe1_pos_y (pipe1_pos_y),
        .pipe2_pos_y (pipe2_pos_y),
        .pipe3_pos_y (pipe3_pos_y),
        .score       (score),
        .score_pulse (score_pulse)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One frame: new_frame for a single edge, then one idle edge; the pulse is captured after the first.
    task automatic applyStimulus(input logic runV, input logic clearV);
        new_frame = 1'b1;
        run       = runV;
        clear     = clearV;
        @(posedge clk);
        #1;
        lastPulse = score_pulse;
        new_frame = 1'b0;
        clear     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkLayout(input string tag);
        checkOutput({tag, "_y1"}, pipe1_pos_y, 480);
        checkOutput({tag, "_y2"}, pipe2_pos_y, 680);
        checkOutput({tag, "_y3"}, pipe3_pos_y, 880);
        checkOutput({tag, "_x1"}, pipe1_pos_x, 420);
        checkOutput({tag, "_x2"}, pipe2_pos_x, 420);
        checkOutput({tag, "_x3"}, pipe3_pos_x, 420);
        checkOutput({tag, "_score"}, score, 0);
    endtask

    task automatic checkGap(input string tag, input logic signed [15:0] x,
                            input logic signed [15:0] tableValue);
`ifdef PIPE_RANDOM_EN
        checkOutput(tag, (x >= 200 && x <= 711) ? 1 : 0, 1);
`else
        checkOutput(tag, x, tableValue);
`endif
    endtask

    initial begin
        $display("[TB] pipe_gen directed test start");
        rstn      = 1'b0;
        new_frame = 1'b0;
        run       = 1'b0;
        clear     = 1'b0;
        lastPulse = 1'b0;
        @(posedge clk);
        #1;
        checkLayout("reset");
        checkOutput("reset_pulse", score_pulse, 0);
        rstn = 1'b1;

        // First pass: pipe1 crosses the bird on frame 76.
        pulseCount = 0;
        for (int f = 1; f <= 76; f++) begin
            applyStimulus(1'b1, 1'b0);
            pulseCount += int'(lastPulse);
        end
        checkOutput("f76_pulse", lastPulse, 1);
        checkOutput("f76_pulse_count", pulseCount, 1);
        checkOutput("f76_y1", pipe1_pos_y, 100);
        checkOutput("f76_score", score, 1);
        checkOutput("f76_pulse_dropped", score_pulse, 0);

        // Frame 117: pipe1 respawns; pipe2 passed on frame 116.
        for (int f = 77; f <= 117; f++) applyStimulus(1'b1, 1'b0);
        checkOutput("f117_y1", pipe1_pos_y, 495);
        checkOutput("f117_y2", pipe2_pos_y, 95);
        checkOutput("f117_y3", pipe3_pos_y, 295);
        checkGap("f117_x1", pipe1_pos_x, 300);
        checkOutput("f117_x2_kept", pipe2_pos_x, 420);
        checkOutput("f117_score", score, 2);

        // Fifty more frames: pipe3 passes at 156, pipe2 respawns at 157.
        for (int f = 118; f <= 167; f++) applyStimulus(1'b1, 1'b0);
        checkOutput("f167_y2", pipe2_pos_y, 445);
        checkGap("f167_x2", pipe2_pos_x, 500);
        checkOutput("f167_score", score, 3);

        applyStimulus(1'b1, 1'b1);
        checkLayout("clear_run");
        checkOutput("clear_run_pulse", lastPulse, 0);

        // Hold behaviour: run low with frames, then run high without frames.
        for (int f = 0; f < 10; f++) applyStimulus(1'b1, 1'b0);
        checkOutput("run10_y1", pipe1_pos_y, 430);
        for (int f = 0; f < 5; f++) applyStimulus(1'b0, 1'b0);
        checkOutput("idle_y1", pipe1_pos_y, 430);
        checkOutput("idle_y2", pipe2_pos_y, 630);
        checkOutput("idle_pulse", lastPulse, 0);
        run = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("noframe_y1", pipe1_pos_y, 430);
        checkOutput("noframe_y3", pipe3_pos_y, 830);
        checkOutput("noframe_pulse", score_pulse, 0);

        // Long run from a fresh clear: passes every 40 frames starting at 76, saturating at 999.
        applyStimulus(1'b0, 1'b1);
        pulseCount = 0;
        for (int f = 1; f <= 40100; f++) begin
            applyStimulus(1'b1, 1'b0);
            pulseCount += int'(lastPulse);
            if (f == 117) checkGap("long_f117_x1", pipe1_pos_x, 300);
            if (f == 39995) checkOutput("long_score_998", score, 998);
            if (f == 39996) begin
                checkOutput("long_score_999", score, 999);
                checkOutput("long_pulse_999", lastPulse, 1);
            end
            if (f == 40036) begin
                checkOutput("sat_score", score, 999);
                checkOutput("sat_pulse", lastPulse, 1);
            end
        end
        checkOutput("long_score_final", score, 999);
        checkOutput("long_pulse_count", pulseCount, 1001);
        checkOutput("long_y1", pipe1_pos_y, 380);

        // Reset wins over a frame update on the same edge.
        rstn      = 1'b0;
        new_frame = 1'b1;
        run       = 1'b1;
        @(posedge clk);
        #1;
        checkLayout("midframe_reset");
        checkOutput("midframe_reset_pulse", score_pulse, 0);
        rstn      = 1'b1;
        new_frame = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_gen.md
PIPE_GEN -- requirements
Module: pipe_gen

Interface
REQ-001 SHALL have parameter SPEED, default 5, pipe scroll step in pixels per frame.
REQ-002 SHALL have parameter SPACING, default 200, horizontal (y-axis) distance between consecutive pipes.
REQ-003 SHALL have parameter Y_MIN, default -100, leftmost pipe y before respawn.
REQ-004 SHALL have parameter BIRD_Y, default 100, fixed bird y used for pass detection.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-006 SHALL have port rstn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port new_frame, input, 1, one-cycle frame pulse.
REQ-008 SHALL have port run, input, 1, scrolling enable, high while the game is in FLY.
REQ-009 SHALL have port clear, input, 1, reload the initial pipe layout and zero the score.
REQ-010 SHALL have ports pipe1_pos_x, pipe2_pos_x, pipe3_pos_x, output, signed 16, gap centre on the vertical axis.
REQ-011 SHALL have ports pipe1_pos_y, pipe2_pos_y, pipe3_pos_y, output, signed 16, pipe position on the scroll axis.
REQ-012 SHALL have port score, output, 10, pipes passed, saturating.
REQ-013 SHALL have port score_pulse, output, 1, one-cycle pulse per pass.

Function
REQ-014 SHALL update all outputs only on the clock edge where new_frame=1, so they are valid one cycle after new_frame.
REQ-015 SHALL apply priority rstn > clear > run, and SHALL let clear win when clear and run are both high.
REQ-016 SHALL, on clear, load y = 480, 680, 880 and x = 420 for all pipes, set score=0, and leave score_pulse at 0.
REQ-017 SHALL, on run, compute each next_y = y - SPEED as a signed 16-bit value.
REQ-018 SHALL respawn a pipe when next_y < Y_MIN: y <= next_y + 3*SPACING, x <= new gap value.
REQ-019 SHALL keep x unchanged when a pipe does not respawn.
REQ-020 SHALL detect a pass when y > BIRD_Y and next_y <= BIRD_Y.
REQ-021 SHALL, on a pass, pulse score_pulse for exactly one cycle and increment score, saturating at 999.
REQ-022 SHALL hold all pipe and score state with score_pulse=0 when new_frame=1 and neither run nor clear is high.
REQ-023 SHALL hold all state and drive score_pulse=0 on every cycle without new_frame.
REQ-024 SHALL produce gap values only within 200..711.
REQ-025 SHALL give the lowest-numbered pipe the first gap value when more than one pipe respawns on the same frame.

Reset
REQ-026 SHALL, while rstn=0, set all outputs to the clear layout (y 480/680/880, x 420), score=0, score_pulse=0.
REQ-027 SHALL, while rstn=0, load the gap source with its seed.
REQ-028 SHALL, when rstn is asserted mid-frame, override any pending update on that edge.

Configuration
REQ-029 SHALL, with PIPE_RANDOM_EN defined, use gap = 200 + lfsr[8:0].
REQ-030 SHALL, with PIPE_RANDOM_EN defined, use a 16-bit Galois LFSR with taps x^16+x^14+x^13+x^11+1 and seed 16'hACE1.
REQ-031 SHALL, with PIPE_RANDOM_EN defined, advance the LFSR every clock so that gap values depend on button timing.
REQ-032 SHALL, without PIPE_RANDOM_EN, cycle gap through 300, 500, 400, 600 with a 2-bit index that advances once per respawned pipe and resets to 0 on rstn and clear.

Structure
REQ-033 SHALL place the constants for initial y values, initial x, gap base, gap table and score maximum in shared package pipe_pkg.
REQ-034 SHALL implement the LFSR as sub-module pipe_lfsr (clk, rstn, 16-bit state output).

Verification
REQ-035 Bench SHALL cover: rstn=0 one cycle -> pipe y 480/680/880, x 420, score 0.
REQ-036 Bench SHALL cover: run=1, 76 new_frame pulses -> pipe1_pos_y=100, score=1, one score_pulse on frame 76.
REQ-037 Bench SHALL cover: run=1, 117 frames -> pipe1_pos_y=495, pipe1_pos_x in 200..711 (300 without PIPE_RANDOM_EN), pipe3_pos_y=295.
REQ-038 Bench SHALL cover: clear and run high on the same new_frame after 50 frames -> clear layout, score=0, score_pulse=0.
REQ-039 Bench SHALL cover: run=0 with new_frame pulses -> outputs constant; new_frame absent with run=1 -> outputs constant.
REQ-040 Bench SHALL cover: run=1 for 40100 frames -> score stops at 999 while score_pulse continues to pulse on each pass.
